fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter feeding a sync FIFO with credit flow control
//
// Purpose: NUM_REQ writers compete for one FIFO write port. Grants are
// round-robin and depend only on the local credit count. i_Full is only
// used to detect a protocol violation.
// Optional feature macro: FIFO_ARB_LOCK_EN adds the i_Lock port and the
// ARB/LOCKED burst-lock FSM.
//
// Ports:
//   i_Clk        clock, rising edge
//   i_Reset_n    asynchronous active-low reset
//   i_Req        per-writer write request (valid)
//   i_Req_Data   writer k data at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_Lock       per-writer burst lock request (FIFO_ARB_LOCK_EN only)
//   o_Gnt        one-hot combinational accept
//   o_Wr_En      registered FIFO write strobe
//   o_Wr_Data    registered FIFO write data
//   i_Full       FIFO full flag (error check only)
//   i_Rd_Done    one FIFO entry consumed this cycle
//   o_Credits    registered free-entry count
//   o_Err        sticky protocol-error flag
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 16,
    localparam int PTR_W     = $clog2(NUM_REQ),
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset_n,
    input  logic [NUM_REQ-1:0]            i_Req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_Req_Data,
`ifdef FIFO_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            i_Lock,
`endif
    output logic [NUM_REQ-1:0]            o_Gnt,
    output logic                          o_Wr_En,
    output logic [DATA_WIDTH-1:0]         o_Wr_Data,
    input  logic                          i_Full,
    input  logic                          i_Rd_Done,
    output logic [CW-1:0]                 o_Credits,
    output logic                          o_Err
);

    localparam logic [CW-1:0]      DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]   LAST_C  = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_C   = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0] last_ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_found;
    logic             xfer;

`ifdef FIFO_ARB_LOCK_EN
    typedef enum logic {ST_ARB, ST_LOCKED} lock_state_t;
    lock_state_t state, state_nxt;
`endif

    // Grant selection. While locked, the owner is always last_ptr because
    // only it can transfer, so no separate owner register is needed.
    always_comb begin : grant_sel
        logic [PTR_W-1:0] cand;
        int               idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        idx       = 0;
`ifdef FIFO_ARB_LOCK_EN
        state_nxt = state;
`endif
        if (i_Reset_n && (o_Credits != '0)) begin
`ifdef FIFO_ARB_LOCK_EN
            if ((state == ST_LOCKED) && i_Req[last_ptr] && i_Lock[last_ptr]) begin
                gnt_found = 1'b1;
                gnt_idx   = last_ptr;
            end else
`endif
            begin
                for (int i = 1; i <= NUM_REQ; i++) begin
                    idx  = (int'(last_ptr) + i) % NUM_REQ;
                    cand = PTR_W'(idx);
                    if (!gnt_found && i_Req[cand]) begin
                        gnt_found = 1'b1;
                        gnt_idx   = cand;
                    end
                end
            end
        end
`ifdef FIFO_ARB_LOCK_EN
        // Running out of credits must not break an active burst lock.
        if (!((state == ST_LOCKED) && (o_Credits == '0))) begin
            if (gnt_found && i_Lock[gnt_idx])
                state_nxt = ST_LOCKED;
            else
                state_nxt = ST_ARB;
        end
`endif
    end

    assign o_Gnt = gnt_found ? (ONE_C << gnt_idx) : '0;
    assign xfer  = gnt_found;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            last_ptr  <= LAST_C;
            o_Wr_En   <= 1'b0;
            o_Wr_Data <= '0;
            o_Credits <= DEPTH_C;
            o_Err     <= 1'b0;
        end else begin
            o_Wr_En <= xfer;
            if (xfer) begin
                last_ptr  <= gnt_idx;
                o_Wr_Data <= i_Req_Data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            if (xfer && !i_Rd_Done) begin
                o_Credits <= o_Credits - CW'(1);
            end else if (i_Rd_Done && !xfer) begin
                // A read with nothing outstanding is an accounting error;
                // keep credits saturated rather than wrapping.
                if (o_Credits == DEPTH_C)
                    o_Err <= 1'b1;
                else
                    o_Credits <= o_Credits + CW'(1);
            end
            if (o_Wr_En && i_Full)
                o_Err <= 1'b1;
        end
    end

`ifdef FIFO_ARB_LOCK_EN
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n)
            state <= ST_ARB;
        else
            state <= state_nxt;
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int FD = 8;

    logic          i_Clk = 1'b0;
    logic          i_Reset_n;
    logic [NR-1:0] i_Req;
    logic [NR*DW-1:0] i_Req_Data;
    logic [NR-1:0] i_Lock;
    logic [NR-1:0] o_Gnt;
    logic          o_Wr_En;
    logic [DW-1:0] o_Wr_Data;
    logic          i_Full;
    logic          i_Rd_Done;
    logic [3:0]    o_Credits;
    logic          o_Err;

    int checks = 0;
    int errors = 0;

    always #5 i_Clk = ~i_Clk;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .FIFO_DEPTH(FD)) dut (
        .i_Clk      (i_Clk),
        .i_Reset_n  (i_Reset_n),
        .i_Req      (i_Req),
        .i_Req_Data (i_Req_Data),
`ifdef FIFO_ARB_LOCK_EN
        .i_Lock     (i_Lock),
`endif
        .o_Gnt      (o_Gnt),
        .o_Wr_En    (o_Wr_En),
        .o_Wr_Data  (o_Wr_Data),
        .i_Full     (i_Full),
        .i_Rd_Done  (i_Rd_Done),
        .o_Credits  (o_Credits),
        .o_Err      (o_Err)
    );

    task automatic reset_pulse();
        i_Reset_n = 1'b0;
        #1;
        @(posedge i_Clk);
        #1;
        i_Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        i_Reset_n  = 1'b0;
        i_Req      = 4'b1111;
        i_Req_Data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        i_Lock     = '0;
        i_Full     = 1'b0;
        i_Rd_Done  = 1'b0;
        #12;
        checks++;
        if (o_Gnt !== 4'b0000) begin
            errors++; $display("FAIL reset_gnt got=%b exp=0000", o_Gnt);
        end
        #11;
        i_Reset_n = 1'b1;
        #1;
        checks++;
        if (o_Credits !== 4'd8) begin
            errors++; $display("FAIL reset_credits got=%0d exp=8", o_Credits);
        end
        checks++;
        if (o_Wr_En !== 1'b0 || o_Err !== 1'b0 || o_Wr_Data !== 8'h00) begin
            errors++; $display("FAIL reset_outs wr_en=%b err=%b data=%h exp 0/0/00", o_Wr_En, o_Err, o_Wr_Data);
        end
        checks++;
        if (o_Gnt !== 4'b0001) begin
            errors++; $display("FAIL reset_first_gnt got=%b exp=0001", o_Gnt);
        end
        i_Req = '0;
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_gnt;
        @(posedge i_Clk);
        #1;
        i_Req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_gnt = 4'b0001 << (i % 4);
            checks++;
            if (o_Gnt !== exp_gnt) begin
                errors++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, o_Gnt, exp_gnt);
            end
            @(posedge i_Clk);
            #1;
            checks++;
            if (o_Wr_En !== 1'b1 || o_Wr_Data !== 8'hA0 + 8'(i % 4)) begin
                errors++; $display("FAIL rr_wr[%0d] en=%b data=%h exp 1/%h", i, o_Wr_En, o_Wr_Data, 8'hA0 + 8'(i % 4));
            end
            checks++;
            if (o_Credits !== 4'(7 - i)) begin
                errors++; $display("FAIL rr_credits[%0d] got=%0d exp=%0d", i, o_Credits, 7 - i);
            end
        end
        #1;
        checks++;
        if (o_Gnt !== 4'b0000) begin
            errors++; $display("FAIL rr_exhausted_gnt got=%b exp=0000", o_Gnt);
        end
        @(posedge i_Clk);
        #1;
        checks++;
        if (o_Wr_En !== 1'b0 || o_Wr_Data !== 8'hA3) begin
            errors++; $display("FAIL rr_idle en=%b data=%h exp 0/a3", o_Wr_En, o_Wr_Data);
        end
    endtask

    task automatic test_credit_return();
        i_Rd_Done = 1'b1;
        #1;
        checks++;
        if (o_Gnt !== 4'b0000) begin
            errors++; $display("FAIL cr_zero_gnt got=%b exp=0000", o_Gnt);
        end
        @(posedge i_Clk);
        #1;
        i_Rd_Done = 1'b0;
        checks++;
        if (o_Credits !== 4'd1) begin
            errors++; $display("FAIL cr_one got=%0d exp=1", o_Credits);
        end
        #1;
        checks++;
        if (o_Gnt !== 4'b0001) begin
            errors++; $display("FAIL cr_gnt got=%b exp=0001", o_Gnt);
        end
        @(posedge i_Clk);
        #1;
        checks++;
        if (o_Credits !== 4'd0 || o_Gnt !== 4'b0000 || o_Wr_Data !== 8'hA0) begin
            errors++; $display("FAIL cr_single credits=%0d gnt=%b data=%h exp 0/0000/a0", o_Credits, o_Gnt, o_Wr_Data);
        end
        i_Req     = '0;
        i_Rd_Done = 1'b1;
        repeat (5) @(posedge i_Clk);
        #1;
        checks++;
        if (o_Credits !== 4'd5) begin
            errors++; $display("FAIL cr_five got=%0d exp=5", o_Credits);
        end
        i_Req = 4'b1111;
        #1;
        checks++;
        if (o_Gnt !== 4'b0010) begin
            errors++; $display("FAIL cr_both_gnt got=%b exp=0010", o_Gnt);
        end
        @(posedge i_Clk);
        #1;
        i_Req     = '0;
        i_Rd_Done = 1'b0;
        checks++;
        if (o_Credits !== 4'd5 || o_Wr_Data !== 8'hA1) begin
            errors++; $display("FAIL cr_both credits=%0d data=%h exp 5/a1", o_Credits, o_Wr_Data);
        end
    endtask

    task automatic test_async_reset();
        @(posedge i_Clk);
        #1;
        i_Req = 4'b1111;
        @(posedge i_Clk);
        #1;
        i_Req = '0;
        checks++;
        if (o_Wr_En !== 1'b1 || o_Wr_Data !== 8'hA2) begin
            errors++; $display("FAIL ar_pre en=%b data=%h exp 1/a2", o_Wr_En, o_Wr_Data);
        end
        #1;
        i_Reset_n = 1'b0;
        #1;
        checks++;
        if (o_Wr_En !== 1'b0 || o_Credits !== 4'd8 || o_Wr_Data !== 8'h00) begin
            errors++; $display("FAIL ar_now en=%b credits=%0d data=%h exp 0/8/00", o_Wr_En, o_Credits, o_Wr_Data);
        end
        @(posedge i_Clk);
        #1;
        i_Reset_n = 1'b1;
    endtask

    task automatic test_errors();
        i_Req = 4'b0001;
        @(posedge i_Clk);
        #1;
        i_Req  = '0;
        i_Full = 1'b1;
        #1;
        checks++;
        if (o_Wr_En !== 1'b1 || o_Err !== 1'b0) begin
            errors++; $display("FAIL err_pre en=%b err=%b exp 1/0", o_Wr_En, o_Err);
        end
        @(posedge i_Clk);
        #1;
        i_Full = 1'b0;
        checks++;
        if (o_Err !== 1'b1) begin
            errors++; $display("FAIL err_full got=%b exp=1", o_Err);
        end
        repeat (3) @(posedge i_Clk);
        #1;
        checks++;
        if (o_Err !== 1'b1) begin
            errors++; $display("FAIL err_sticky got=%b exp=1", o_Err);
        end
        reset_pulse();
        checks++;
        if (o_Err !== 1'b0) begin
            errors++; $display("FAIL err_cleared got=%b exp=0", o_Err);
        end
        i_Rd_Done = 1'b1;
        @(posedge i_Clk);
        #1;
        i_Rd_Done = 1'b0;
        checks++;
        if (o_Err !== 1'b1 || o_Credits !== 4'd8) begin
            errors++; $display("FAIL err_overread err=%b credits=%0d exp 1/8", o_Err, o_Credits);
        end
    endtask

`ifdef FIFO_ARB_LOCK_EN
    task automatic test_lock();
        reset_pulse();
        i_Req = 4'b0010;
        @(posedge i_Clk);
        #1;
        i_Req  = 4'b1111;
        i_Lock = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (o_Gnt !== 4'b0100) begin
                errors++; $display("FAIL lock_gnt[%0d] got=%b exp=0100", i, o_Gnt);
            end
            @(posedge i_Clk);
            #1;
        end
        i_Lock = '0;
        #1;
        checks++;
        if (o_Gnt !== 4'b1000) begin
            errors++; $display("FAIL lock_release got=%b exp=1000", o_Gnt);
        end
        @(posedge i_Clk);
        #1;
        i_Req = '0;
        checks++;
        if (o_Wr_Data !== 8'hA3 || o_Credits !== 4'd2) begin
            errors++; $display("FAIL lock_after data=%h credits=%0d exp a3/2", o_Wr_Data, o_Credits);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_credit_return();
        test_async_reset();
`ifdef FIFO_ARB_LOCK_EN
        test_lock();
`endif
        test_errors();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
